// File: rtl/codec_cfg_pkg.sv
// Shared types and boot-table constants for the codec configuration sequencer.
// No logic beyond the frame packing helper.
package codec_cfg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD      = 3'd1;
    localparam state_t ST_GO        = 3'd2;
    localparam state_t ST_WAIT_BUSY = 3'd3;
    localparam state_t ST_WAIT_DONE = 3'd4;
    localparam state_t ST_SETTLE    = 3'd5;
    localparam state_t ST_DONE      = 3'd6;
    localparam state_t ST_ERROR     = 3'd7;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] val;
    } cfg_word_t;

    typedef struct packed {
        logic [7:0] dev_addr;
        logic [6:0] reg_addr;
        logic [8:0] val;
    } frame_t;

    localparam int BOOT_LEN = 11;

    // Codec reset first, activation (R9) last.
    localparam cfg_word_t BOOT_TABLE [0:BOOT_LEN-1] = '{
        '{7'd15, 9'h000},
        '{7'd0,  9'h017},
        '{7'd1,  9'h017},
        '{7'd2,  9'h079},
        '{7'd3,  9'h079},
        '{7'd4,  9'h012},
        '{7'd5,  9'h000},
        '{7'd6,  9'h000},
        '{7'd7,  9'h042},
        '{7'd8,  9'h019},
        '{7'd9,  9'h001}
    };

    function automatic frame_t pack_frame(input logic [7:0] dev, input cfg_word_t w);
        frame_t f;
        f.dev_addr = dev;
        f.reg_addr = w.reg_addr;
        f.val      = w.val;
        return f;
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Handshake between the sequencer (master) and the I2C write engine (slave).
// GO is a one-cycle pulse; data is held until the engine raises ready again.
interface codec_cfg_sequencer_if;
    logic        eng_go;
    logic [23:0] eng_data;
    logic        eng_ready;

    modport master (output eng_go, output eng_data, input eng_ready);
    modport slave  (input eng_go, input eng_data, output eng_ready);
endinterface

// File: rtl/codec_cfg_rom.sv
// Boot table lookup: index -> {reg, val}.
// Latency: combinational. Backpressure: none.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_WORDS = 11
) (
    input  logic [3:0] idx,
    output cfg_word_t  word
);

    always_comb begin
        word = '0;
        if (int'(idx) < NUM_WORDS && int'(idx) < BOOT_LEN)
            word = BOOT_TABLE[idx];
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Boot/runtime codec register writer with watchdog and retry; runtime writes under CODEC_CFG_RUNTIME_WR_EN.
// Latency: first GO two edges after reset release; per word 3 + engine time + SETTLE_CYC.
// Backpressure: waits on eng_ready; wr_req is only accepted in DONE.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_WORDS   = 11,
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         SETTLE_CYC  = 4,
    parameter int         TIMEOUT_CYC = 64,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    codec_cfg_sequencer_if.master eng,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            idx
`ifdef CODEC_CFG_RUNTIME_WR_EN
    ,
    input  logic                  wr_req,
    input  logic [6:0]            wr_reg,
    input  logic [8:0]            wr_val,
    output logic                  wr_gnt
`endif
);

    state_t      state, state_nxt;
    logic        go_q;
    frame_t      data_q;
    logic [15:0] wdog;
    logic [15:0] settle_cnt;
    logic [3:0]  retry;
    logic        rt_active;
    logic        rt_take;
    frame_t      rt_frame;
    cfg_word_t   rom_word;

    logic wd_expire, settle_last, last_word, retry_ok;

    codec_cfg_rom #(.NUM_WORDS(NUM_WORDS)) u_rom (
        .idx  (idx),
        .word (rom_word)
    );

`ifdef CODEC_CFG_RUNTIME_WR_EN
    assign rt_take  = (state == ST_DONE) && wr_req && !start;
    assign wr_gnt   = rt_take;
    assign rt_frame = '{dev_addr: DEV_ADDR, reg_addr: wr_reg, val: wr_val};
`else
    assign rt_take  = 1'b0;
    assign rt_frame = '0;
`endif

    // wdog holds (cycles since GO) - 1, so expiry lands the retry GO exactly TIMEOUT_CYC after the last one.
    assign wd_expire   = (wdog >= 16'(TIMEOUT_CYC - 2));
    assign settle_last = (settle_cnt == 16'(SETTLE_CYC - 1));
    assign last_word   = (idx == 4'(NUM_WORDS - 1));
    assign retry_ok    = (retry < 4'(MAX_RETRY));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_GO;
            ST_GO:        state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!eng.eng_ready)  state_nxt = ST_WAIT_DONE;
                else if (wd_expire)  state_nxt = retry_ok ? ST_GO : ST_ERROR;
            end
            // ready wins over a simultaneous watchdog expiry
            ST_WAIT_DONE: begin
                if (eng.eng_ready)   state_nxt = ST_SETTLE;
                else if (wd_expire)  state_nxt = retry_ok ? ST_GO : ST_ERROR;
            end
            ST_SETTLE: begin
                if (settle_last)     state_nxt = (rt_active || last_word) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                if (start)           state_nxt = ST_IDLE;
                else if (rt_take)    state_nxt = ST_LOAD;
            end
            ST_ERROR: begin
                if (start)           state_nxt = ST_IDLE;
            end
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            go_q       <= 1'b0;
            data_q     <= '0;
            idx        <= '0;
            err        <= 1'b0;
            retry      <= '0;
            wdog       <= '0;
            settle_cnt <= '0;
            rt_active  <= 1'b0;
        end else begin
            state <= state_nxt;
            go_q  <= (state_nxt == ST_GO);
            case (state)
                ST_LOAD: begin
                    if (!rt_active)
                        data_q <= pack_frame(DEV_ADDR, rom_word);
                end
                ST_GO: wdog <= '0;
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    wdog <= wdog + 16'd1;
                    if (state_nxt == ST_GO)     retry <= retry + 4'd1;
                    if (state_nxt == ST_ERROR)  err   <= 1'b1;
                    if (state_nxt == ST_SETTLE) begin
                        retry      <= '0;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (state_nxt != ST_SETTLE) begin
                        rt_active <= 1'b0;
                        if (state_nxt == ST_LOAD)
                            idx <= idx + 4'd1;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        idx       <= '0;
                        err       <= 1'b0;
                        retry     <= '0;
                        rt_active <= 1'b0;
                    end else if (rt_take) begin
                        rt_active <= 1'b1;
                        data_q    <= rt_frame;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng.eng_go   = go_q;
    assign eng.eng_data = data_q;
    assign busy         = (state != ST_DONE) && (state != ST_ERROR);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench: expected frames are queued by stimulus and popped by a monitor on every eng_go.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [3:0] idx;
`ifdef CODEC_CFG_RUNTIME_WR_EN
    logic       wr_req = 1'b0;
    logic [6:0] wr_reg = '0;
    logic [8:0] wr_val = '0;
    logic       wr_gnt;
`endif

    codec_cfg_sequencer_if eng_if();

    codec_cfg_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .eng    (eng_if),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .idx    (idx)
`ifdef CODEC_CFG_RUNTIME_WR_EN
        ,
        .wr_req (wr_req),
        .wr_reg (wr_reg),
        .wr_val (wr_val),
        .wr_gnt (wr_gnt)
`endif
    );

    always #5 clk = ~clk;

    logic [23:0] boot_frames [11] = '{
        24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
        24'h340A00, 24'h340C00, 24'h340E42, 24'h341019, 24'h341201
    };

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          go_count = 0;
    int          gnt_count = 0;
    logic [23:0] exp_q [$];
    int          go_cyc [$];
    logic [23:0] exp_head;

    bit          dead = 1'b0;
    int          nack_left = 0;
    logic [23:0] nack_frame = '0;
    int          busy_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: ACKs in 34 cycles, a matching NACK frame stretches one transfer past the watchdog.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            eng_if.eng_ready = 1'b1;
            busy_left        = 0;
        end else if (eng_if.eng_go && !dead) begin
            if (nack_left > 0 && eng_if.eng_data == nack_frame) begin
                busy_left = 80;
                nack_left--;
            end else begin
                busy_left = 34;
            end
            eng_if.eng_ready = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) eng_if.eng_ready = 1'b1;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            if (eng_if.eng_go) begin
                go_count++;
                go_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_go: frame 0x%06h with none expected", eng_if.eng_data);
                end else begin
                    exp_head = exp_q.pop_front();
                    check("go_frame", {8'h0, eng_if.eng_data}, {8'h0, exp_head});
                end
            end
`ifdef CODEC_CFG_RUNTIME_WR_EN
            if (wr_gnt) gnt_count++;
`endif
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, done}, 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_eng_go"},   {31'h0, eng_if.eng_go}, 32'd0);
        check({tag, "_eng_data"}, {8'h0, eng_if.eng_data}, 32'h0);
        check({tag, "_busy"},     {31'h0, busy}, 32'd1);
        check({tag, "_done"},     {31'h0, done}, 32'd0);
        check({tag, "_err"},      {31'h0, err},  32'd0);
        check({tag, "_idx"},      {28'h0, idx},  32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Boot after reset release: all eleven words, in order
        foreach (boot_frames[i]) exp_q.push_back(boot_frames[i]);
        reset = 1'b1;
        wait_done("boot_done");
        check("boot_go_count", go_count, 11);
        check("boot_err", {31'h0, err}, 32'd0);
        check("boot_idx", {28'h0, idx}, 32'd10);
        check("boot_busy", {31'h0, busy}, 32'd0);
        check("boot_queue_empty", exp_q.size(), 0);

        // One NACKed transfer on word 3 forces a single retry
        go_count   = 0;
        nack_frame = 24'h340479;
        nack_left  = 1;
        foreach (boot_frames[i]) begin
            exp_q.push_back(boot_frames[i]);
            if (i == 3) exp_q.push_back(boot_frames[i]);
        end
        pulse_start();
        check("nack_busy_after_start", {31'h0, busy}, 32'd1);
        wait_done("nack_done");
        check("nack_go_count", go_count, 12);
        check("nack_err", {31'h0, err}, 32'd0);

        // Reset while word 5 is in flight
        go_count = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(boot_frames[i]);
        pulse_start();
        n = 0;
        while (!(idx == 4'd5 && eng_if.eng_ready == 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_idx5", {28'h0, idx}, 32'd5);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        foreach (boot_frames[i]) exp_q.push_back(boot_frames[i]);
        reset = 1'b1;
        wait_done("midrst_done");
        check("midrst_go_count", go_count, 17);

        // Engine never starts: four GOs TIMEOUT_CYC apart, then ERROR
        dead     = 1'b1;
        go_count = 0;
        go_cyc.delete();
        repeat (4) exp_q.push_back(24'h341E00);
        pulse_start();
        n = 0;
        while (err !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("dead_err", {31'h0, err}, 32'd1);
        check("dead_done", {31'h0, done}, 32'd0);
        check("dead_busy", {31'h0, busy}, 32'd0);
        check("dead_idx", {28'h0, idx}, 32'd0);
        check("dead_go_count", go_count, 4);
        if (go_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("dead_go_spacing", go_cyc[i] - go_cyc[i-1], 64);
        repeat (100) @(negedge clk);
        check("error_holds_no_go", go_count, 4);
        check("error_holds_err", {31'h0, err}, 32'd1);

        dead     = 1'b0;
        go_count = 0;
        foreach (boot_frames[i]) exp_q.push_back(boot_frames[i]);
        pulse_start();
        check("start_clears_err", {31'h0, err}, 32'd0);
        wait_done("recover_done");
        check("recover_go_count", go_count, 11);

`ifdef CODEC_CFG_RUNTIME_WR_EN
        // Runtime write from DONE returns to DONE with idx untouched
        go_count  = 0;
        gnt_count = 0;
        exp_q.push_back(24'h34047F);
        @(posedge clk); #1 wr_reg = 7'h02; wr_val = 9'h07F; wr_req = 1'b1;
        @(posedge clk); #1 wr_req = 1'b0;
        check("rt_busy", {31'h0, busy}, 32'd1);
        wait_done("rt_done");
        check("rt_gnt_count", gnt_count, 1);
        check("rt_go_count", go_count, 1);
        check("rt_idx", {28'h0, idx}, 32'd10);

        // start beats wr_req in the same cycle
        foreach (boot_frames[i]) exp_q.push_back(boot_frames[i]);
        @(posedge clk); #1 start = 1'b1; wr_req = 1'b1; wr_reg = 7'h05; wr_val = 9'h1FF;
        @(posedge clk); #1 start = 1'b0; wr_req = 1'b0;
        wait_done("start_wins_done");
        check("start_wins_gnt", gnt_count, 1);
        check("start_wins_go_count", go_count, 12);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
